// File: rtl/pc_demux.sv
`default_nettype none
// ============================================================================
// Module   : pc_demux
// Brief    : Registered 1-to-2 demux for the PC datapath. in_sel chooses the
//            sink, and each sink owns a one-entry valid/ready output slot.
//            Per-port delivery counters are present when DEMUX_STATS_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module pc_demux #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
`ifdef DEMUX_STATS_EN
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
`endif
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

  slot_state_e      state_q [2];
  slot_state_e      state_d [2];
  logic [WIDTH-1:0] data_q  [2];
  logic [WIDTH-1:0] data_d  [2];

  logic [1:0] slot_valid;
  logic [1:0] slot_ready;
  logic [1:0] drain;
  logic [1:0] load;
  logic       accept;

  assign slot_valid = {state_q[1] == ST_FULL, state_q[0] == ST_FULL};
  assign slot_ready = {out1_ready, out0_ready};
  assign drain      = slot_valid & slot_ready;

  // A slot can take a new word when it is empty or emptying this cycle.
  assign in_ready = ~slot_valid[in_sel] | slot_ready[in_sel];
  assign accept   = in_valid & in_ready;
  assign load     = {accept & in_sel, accept & ~in_sel};

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      state_d[n] = state_q[n];
      data_d[n]  = data_q[n];
      case (state_q[n])
        ST_EMPTY: if (load[n]) state_d[n] = ST_FULL;
        ST_FULL:  if (drain[n] && !load[n]) state_d[n] = ST_EMPTY;
        default:  state_d[n] = ST_EMPTY;
      endcase
      if (load[n]) data_d[n] = in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) begin
        state_q[n] <= ST_EMPTY;
        data_q[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        state_q[n] <= state_d[n];
        data_q[n]  <= data_d[n];
      end
    end
  end

  assign out0_valid = slot_valid[0];
  assign out1_valid = slot_valid[1];
  assign out0_data  = data_q[0];
  assign out1_data  = data_q[1];

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt_q [2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) cnt_q[n] <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (drain[n]) cnt_q[n] <= cnt_q[n] + CNT_W'(1);
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
`else
  logic unused_cnt_w;
  assign unused_cnt_w = |CNT_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_demux
// Brief    : Directed bench for pc_demux with a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_demux;

  localparam int WIDTH = 6;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid, out1_valid;
  logic             out0_ready, out1_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic [CNT_W-1:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  pc_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
`ifdef DEMUX_STATS_EN
    .cnt0       (cnt0),
    .cnt1       (cnt1),
`endif
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
  );

`ifndef DEMUX_STATS_EN
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each port is a FIFO of accepted-but-undelivered words.
  // A port may hold at most one word; the visible word is the last one loaded.
  logic [WIDTH-1:0] mq [2][$];
  logic [WIDTH-1:0] last_word [2];
  int               delivered [2];

  function automatic bit m_ready(input bit sel);
    return (mq[sel].size() == 0) || (sel ? out1_ready : out0_ready);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) begin
        mq[n].delete();
        last_word[n] = '0;
        delivered[n] = 0;
      end
    end else begin
      bit acc;
      bit rdy [2];
      acc    = in_valid && m_ready(in_sel);
      rdy[0] = out0_ready;
      rdy[1] = out1_ready;
      for (int n = 0; n < 2; n++) begin
        if (mq[n].size() != 0 && rdy[n]) begin
          void'(mq[n].pop_front());
          delivered[n] = (delivered[n] + 1) % (1 << CNT_W);
        end
      end
      if (acc) begin
        mq[in_sel].push_back(in_data);
        last_word[in_sel] = in_data;
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("out0_valid", int'(out0_valid), int'(mq[0].size() != 0));
      check("out1_valid", int'(out1_valid), int'(mq[1].size() != 0));
      check("out0_data",  int'(out0_data),  int'(last_word[0]));
      check("out1_data",  int'(out1_data),  int'(last_word[1]));
      check("in_ready",   int'(in_ready),   int'(m_ready(in_sel)));
      if (mq[0].size() > 1 || mq[1].size() > 1) check("slot_depth", 2, 1);
      if (out0_valid && out0_ready && mq[0].size() != 0)
        check("deliver0", int'(out0_data), int'(mq[0][0]));
      if (out1_valid && out1_ready && mq[1].size() != 0)
        check("deliver1", int'(out1_data), int'(mq[1][0]));
`ifdef DEMUX_STATS_EN
      check("cnt0", int'(cnt0), delivered[0]);
      check("cnt1", int'(cnt1), delivered[1]);
`endif
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_sel     = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    cyc(2);
    reset = 1'b0;
    #1;
    check("rst_out0_valid", int'(out0_valid), 0);
    check("rst_out1_valid", int'(out1_valid), 0);
    check("rst_out0_data",  int'(out0_data),  0);
    check("rst_out1_data",  int'(out1_data),  0);
    check("rst_in_ready",   int'(in_ready),   1);
    cyc(1);

    // First word to stalled port 0.
    in_valid = 1'b1; in_sel = 1'b0; in_data = 6'h15;
    cyc(1);
    check("t1_out0_valid", int'(out0_valid), 1);
    check("t1_out0_data",  int'(out0_data),  6'h15);
    check("t1_out1_valid", int'(out1_valid), 0);
    check("t1_in_ready",   int'(in_ready),   0);

    // Port 1 still flows while port 0 is stalled.
    in_sel = 1'b1; in_data = 6'h2A; out1_ready = 1'b1;
    #1;
    check("t2_in_ready", int'(in_ready), 1);
    cyc(1);
    in_valid = 1'b0;
    check("t2_out1_valid", int'(out1_valid), 1);
    check("t2_out1_data",  int'(out1_data),  6'h2A);
    check("t2_out0_data",  int'(out0_data),  6'h15);
    cyc(1);
    check("t2_out1_drained", int'(out1_valid), 0);

    // Streaming on port 0 with no bubble.
    out0_ready = 1'b1; in_sel = 1'b0; in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_data = WIDTH'(i);
      cyc(1);
      check("t3_stream_data",  int'(out0_data),  i);
      check("t3_stream_valid", int'(out0_valid), 1);
    end
    in_valid = 1'b0;
    cyc(1);

    // Alternating destinations, one word per cycle total.
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_sel  = i[0];
      in_data = WIDTH'(6'h30 + i);
      cyc(1);
    end
    in_valid = 1'b0;
    cyc(1);
    check("t4_last_out1", int'(out1_data), 6'h35);
    check("t4_last_out0", int'(out0_data), 6'h34);

    // Back-pressure on port 1, then release.
    out1_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b1; in_data = 6'h11;
    cyc(1);
    in_data = 6'h12;
    cyc(3);
    check("t5_hold_data", int'(out1_data), 6'h11);
    out1_ready = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    check("t5_next_data", int'(out1_data), 6'h12);
    cyc(2);

    // Asynchronous reset while both slots are full.
    out0_ready = 1'b0; out1_ready = 1'b0; in_valid = 1'b1;
    in_sel = 1'b0; in_data = 6'h0C; cyc(1);
    in_sel = 1'b1; in_data = 6'h0D; cyc(1);
    in_valid = 1'b0;
    check("t6_both_full", int'(out0_valid & out1_valid), 1);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_out0_valid", int'(out0_valid), 0);
    check("t6_rst_out1_valid", int'(out1_valid), 0);
    check("t6_rst_data", int'({out0_data, out1_data}), 0);
    check("t6_rst_cnt",  int'({cnt0, cnt1}), 0);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    check("t6_no_spurious", int'(out0_valid | out1_valid), 0);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 6'h3F; out0_ready = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    check("t6_post_valid", int'(out0_valid), 1);
    check("t6_post_data",  int'(out0_data),  6'h3F);
    cyc(1);

    // Counter wrap: 257 drains on port 1, 3 on port 0, one pair together.
    do_reset();
    out0_ready = 1'b0; out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 6'h21;
    cyc(1);
    in_sel = 1'b1;
    for (int i = 0; i < 257; i++) begin
      in_data = WIDTH'(i);
      cyc(1);
    end
    in_valid = 1'b0; out0_ready = 1'b1;
    cyc(1);
    in_valid = 1'b1; in_sel = 1'b0;
    in_data = 6'h22; cyc(1);
    in_data = 6'h23; cyc(1);
    in_valid = 1'b0;
    cyc(2);
`ifdef DEMUX_STATS_EN
    check("t7_cnt1_wrap", int'(cnt1), 1);
    check("t7_cnt0",      int'(cnt0), 3);
`endif
    check("t7_empty", int'(out0_valid | out1_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
